// File: rtl/crypt_pkg.sv
// Shared types and width-generic rotate helpers for the streaming cipher core.
// The rotates work on a CRYPT_MAX_W container; callers cast in and out at their own width.
package crypt_pkg;

    localparam int CRYPT_MAX_W = 64;

    typedef enum logic [1:0] {
        ENC      = 2'd0,
        DEC      = 2'd1,
        LOOPBACK = 2'd2,
        RESERVED = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic logic [CRYPT_MAX_W-1:0] rotl1(input logic [CRYPT_MAX_W-1:0] v,
                                                     input int w);
        logic [CRYPT_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < CRYPT_MAX_W; i++) begin
            if (i < w) r[(i + 1) % w] = v[i];
        end
        return r;
    endfunction

    function automatic logic [CRYPT_MAX_W-1:0] rotr1(input logic [CRYPT_MAX_W-1:0] v,
                                                     input int w);
        logic [CRYPT_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < CRYPT_MAX_W; i++) begin
            if (i < w) r[i] = v[(i + 1) % w];
        end
        return r;
    endfunction

endpackage

// File: rtl/crypt_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy output.
// A push is accepted when full only if a pop happens on the same edge.
module crypt_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_valid   = (r_count != '0);
    assign w_do_pop  = i_pop & o_valid;
    assign w_do_push = i_push & ((r_count != FULL_CNT) | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head is masked so dout reads as zero whenever nothing is queued.
    assign o_dout  = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;

endmodule

// File: rtl/encrypt_decrypt_stream_core.sv
// Streaming rolling-key cipher: IDLE/RUN/DRAIN control, two-stage pipeline
// (cipher, then optional loopback self-check) feeding an output FIFO.
module encrypt_decrypt_stream_core
    import crypt_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  mode_t             mode,
    input  logic              key_load,
    input  logic [DATA_W-1:0] key_in,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              err,
    output logic [CNT_W-1:0]  word_count
);
    localparam int            AW        = $clog2(FIFO_DEPTH);
    localparam int            OW        = AW + 2;
    localparam logic [OW-1:0] OCC_LIMIT = OW'(FIFO_DEPTH - 1);

    state_t            r_state;
    state_t            w_state_next;
    mode_t             r_mode;
    logic [DATA_W-1:0] r_key;
    logic              r_err;
    logic [CNT_W-1:0]  r_word_count;

    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_y;
    logic [DATA_W-1:0] r_s1_k;
    logic [DATA_W-1:0] r_s1_din;
    logic              r_s2_valid;
    logic [DATA_W-1:0] r_s2_y;

    logic [AW:0]       w_fifo_count;
    logic [OW-1:0]     w_occupancy;
    logic              w_fifo_valid;
    logic              w_accept;
    logic              w_pop;
    logic              w_pipe_empty;
    logic [DATA_W-1:0] w_enc_y;
    logic [DATA_W-1:0] w_dec_y;
    logic [DATA_W-1:0] w_s1_y;
    logic [DATA_W-1:0] w_lb_z;
    logic [DATA_W-1:0] w_key_rot;

    // Words already in the pipeline count against FIFO space, so a push never finds it full.
    assign w_occupancy  = OW'(w_fifo_count) + OW'(r_s1_valid) + OW'(r_s2_valid);
    assign din_ready    = (r_state == RUN) && (w_occupancy <= OCC_LIMIT);
    assign w_accept     = din_valid & din_ready;
    assign w_pop        = w_fifo_valid & dout_ready;
    assign w_pipe_empty = ~r_s1_valid & ~r_s2_valid;

    assign w_enc_y   = DATA_W'(rotl1(CRYPT_MAX_W'(din ^ r_key), DATA_W));
    assign w_dec_y   = DATA_W'(rotr1(CRYPT_MAX_W'(din), DATA_W)) ^ r_key;
    assign w_s1_y    = (r_mode == DEC) ? w_dec_y : w_enc_y;
    assign w_lb_z    = DATA_W'(rotr1(CRYPT_MAX_W'(r_s1_y), DATA_W)) ^ r_s1_k;
    assign w_key_rot = DATA_W'(rotl1(CRYPT_MAX_W'(r_key), DATA_W));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (enable) w_state_next = RUN;
            RUN:     if (!enable) w_state_next = DRAIN;
            DRAIN: begin
                if (enable)                             w_state_next = RUN;
                else if (w_pipe_empty && !w_fifo_valid) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode <= ENC;
            r_key  <= '0;
            r_err  <= 1'b0;
        end else begin
            if (r_state == IDLE) begin
                if (key_load) r_key  <= key_in;
                if (enable)   r_mode <= mode;
            end else if (w_accept) begin
                r_key <= w_key_rot;
            end
            if ((r_state == IDLE) && key_load)
                r_err <= 1'b0;
            else if (r_s1_valid && (r_mode == LOOPBACK) && (w_lb_z != r_s1_din))
                r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_y       <= '0;
            r_s1_k       <= '0;
            r_s1_din     <= '0;
            r_s2_valid   <= 1'b0;
            r_s2_y       <= '0;
            r_word_count <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_y   <= w_s1_y;
                r_s1_k   <= r_key;
                r_s1_din <= din;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) r_s2_y <= r_s1_y;
            if (w_pop) r_word_count <= r_word_count + 1'b1;
        end
    end

    crypt_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (r_s2_valid),
        .i_din   (r_s2_y),
        .i_pop   (dout_ready),
        .o_dout  (dout),
        .o_valid (w_fifo_valid),
        .o_count (w_fifo_count)
    );

    assign dout_valid = w_fifo_valid;
    assign busy       = (r_state != IDLE);
    assign err        = r_err;
    assign word_count = r_word_count;

endmodule

// File: tb/tb_encrypt_decrypt_stream_core.sv
// Directed bench for encrypt_decrypt_stream_core (DATA_W=8, FIFO_DEPTH=8, CNT_W=16).
module tb_encrypt_decrypt_stream_core;
    import crypt_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    mode_t       mode = ENC;
    logic        key_load = 1'b0;
    logic [7:0]  key_in = 8'h00;
    logic [7:0]  din = 8'h00;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic        busy;
    logic        err;
    logic [15:0] word_count;

    int   total = 0;
    int   bad = 0;
    int   sent;
    int   rcv;
    logic rdy;

    always #5 clk = ~clk;

    encrypt_decrypt_stream_core #(
        .DATA_W     (8),
        .FIFO_DEPTH (8),
        .CNT_W      (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .mode       (mode),
        .key_load   (key_load),
        .key_in     (key_in),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .err        (err),
        .word_count (word_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load_key(input logic [7:0] k);
        key_load = 1'b1;
        key_in   = k;
        @(negedge clk);
        key_load = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int c = 0;
        while (busy !== 1'b0 && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    // Offers words back to back; a word counts as sent when din_ready was high before the edge.
    task automatic stream(input int n, input bit rnd, input int max_cyc, output int nsent);
        int   cyc = 0;
        logic r;
        nsent     = 0;
        din_valid = 1'b1;
        din       = rnd ? 8'($urandom) : 8'h01;
        while (nsent < n && cyc < max_cyc) begin
            r = din_ready;
            @(negedge clk);
            cyc++;
            if (r) begin
                nsent++;
                din = rnd ? 8'($urandom) : 8'h01;
            end
        end
        din_valid = 1'b0;
    endtask

    initial begin
        // Power-on reset
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_din_ready", 32'(din_ready), 32'd0);
        chk("rst_dout_valid", 32'(dout_valid), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // ENC: key A5, 3C,3C -> 33,EE; two-edge latency
        mode = ENC;
        load_key(8'hA5);
        enable = 1'b1;
        @(negedge clk);
        chk("enc_busy", 32'(busy), 32'd1);
        chk("enc_din_ready", 32'(din_ready), 32'd1);
        din = 8'h3C;
        din_valid = 1'b1;
        @(negedge clk);
        chk("enc_lat_n0", 32'(dout_valid), 32'd0);
        @(negedge clk);
        din_valid = 1'b0;
        chk("enc_lat_n1", 32'(dout_valid), 32'd0);
        @(negedge clk);
        chk("enc_lat_n2", 32'(dout_valid), 32'd1);
        chk("enc_word0", 32'(dout), 32'h33);
        dout_ready = 1'b1;
        @(negedge clk);
        chk("enc_word1", 32'(dout), 32'hEE);
        chk("enc_wc1", 32'(word_count), 32'd1);
        @(negedge clk);
        chk("enc_empty", 32'(dout_valid), 32'd0);
        chk("enc_wc2", 32'(word_count), 32'd2);
        enable = 1'b0;
        wait_idle("enc_idle");

        // DEC: key A5, 33,EE -> 3C,3C
        mode = DEC;
        load_key(8'hA5);
        enable = 1'b1;
        @(negedge clk);
        din = 8'h33;
        din_valid = 1'b1;
        @(negedge clk);
        din = 8'hEE;
        @(negedge clk);
        din_valid = 1'b0;
        @(negedge clk);
        chk("dec_word0", 32'(dout), 32'h3C);
        @(negedge clk);
        chk("dec_word1", 32'(dout), 32'h3C);
        @(negedge clk);
        chk("dec_empty", 32'(dout_valid), 32'd0);
        chk("dec_wc", 32'(word_count), 32'd4);
        enable = 1'b0;
        wait_idle("dec_idle");

        // Reset asserted mid-stream
        mode = ENC;
        load_key(8'h5A);
        enable = 1'b1;
        dout_ready = 1'b0;
        @(negedge clk);
        din = 8'h11;
        din_valid = 1'b1;
        repeat (4) @(negedge clk);
        chk("mid_pre_valid", 32'(dout_valid), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_din_ready", 32'(din_ready), 32'd0);
        chk("mid_dout_valid", 32'(dout_valid), 32'd0);
        chk("mid_dout", 32'(dout), 32'd0);
        chk("mid_err", 32'(err), 32'd0);
        chk("mid_word_count", 32'(word_count), 32'd0);
        enable = 1'b0;
        din_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_dout_valid", 32'(dout_valid), 32'd0);

        // LOOPBACK: 256 random words
        mode = LOOPBACK;
        load_key(8'hC3);
        enable = 1'b1;
        dout_ready = 1'b1;
        @(negedge clk);
        stream(256, 1'b1, 2000, sent);
        chk("lb_sent", 32'(sent), 32'd256);
        enable = 1'b0;
        wait_idle("lb_idle");
        chk("lb_err", 32'(err), 32'd0);
        chk("lb_wc", 32'(word_count), 32'd256);

        // Flip one bit of the stage-1 copy of din: 00 seen as 01
        enable = 1'b1;
        @(negedge clk);
        force dut.r_s1_din = 8'h01;
        din = 8'h00;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        @(negedge clk);
        release dut.r_s1_din;
        chk("lb_flip_err", 32'(err), 32'd1);
        enable = 1'b0;
        wait_idle("lb_flip_idle");
        chk("lb_err_sticky", 32'(err), 32'd1);
        mode = ENC;
        load_key(8'h00);
        chk("lb_err_cleared", 32'(err), 32'd0);

        // Backpressure: key 0 so each output is din shifted left by one
        enable = 1'b1;
        dout_ready = 1'b0;
        @(negedge clk);
        sent = 0;
        for (int c = 0; c < 20; c++) begin
            rdy = din_ready;
            din_valid = 1'b1;
            din = 8'(sent + 1);
            @(negedge clk);
            if (rdy) sent++;
        end
        chk("bp_accepted", 32'(sent), 32'd8);
        chk("bp_din_ready", 32'(din_ready), 32'd0);
        dout_ready = 1'b1;
        rcv = 0;
        for (int c = 0; c < 200 && rcv < 12; c++) begin
            rdy = din_ready;
            din_valid = (sent < 12);
            din = 8'(sent + 1);
            if (dout_valid) begin
                chk("bp_order", 32'(dout), 32'(2 * (rcv + 1)));
                rcv++;
            end
            @(negedge clk);
            if (rdy && sent < 12) sent++;
        end
        din_valid = 1'b0;
        chk("bp_sent", 32'(sent), 32'd12);
        chk("bp_rcv", 32'(rcv), 32'd12);
        enable = 1'b0;
        wait_idle("bp_idle");
        chk("bp_wc", 32'(word_count), 32'h10D);

        // Drop enable with words still queued -> DRAIN, then IDLE
        enable = 1'b1;
        dout_ready = 1'b0;
        @(negedge clk);
        din = 8'h10;
        din_valid = 1'b1;
        @(negedge clk);
        din = 8'h11;
        @(negedge clk);
        din_valid = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        chk("drain_busy", 32'(busy), 32'd1);
        chk("drain_din_ready", 32'(din_ready), 32'd0);
        repeat (3) @(negedge clk);
        chk("drain_hold", 32'(busy), 32'd1);
        chk("drain_head", 32'(dout), 32'h20);
        dout_ready = 1'b1;
        @(negedge clk);
        chk("drain_second", 32'(dout), 32'h22);
        wait_idle("drain_idle");
        chk("drain_empty", 32'(dout_valid), 32'd0);
        chk("drain_wc", 32'(word_count), 32'h10F);

        // key_load while running is ignored
        enable = 1'b1;
        dout_ready = 1'b0;
        @(negedge clk);
        key_load = 1'b1;
        key_in = 8'hFF;
        din = 8'h01;
        din_valid = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
        din_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("kl_run_valid", 32'(dout_valid), 32'd1);
        chk("kl_run_dout", 32'(dout), 32'h02);
        dout_ready = 1'b1;
        enable = 1'b0;
        wait_idle("kl_run_idle");
        chk("kl_run_wc", 32'(word_count), 32'h110);

        // word_count wrap: bring it to FFFF, then one more
        enable = 1'b1;
        @(negedge clk);
        stream(65535 - 272, 1'b0, 70000, sent);
        chk("wrap_sent", 32'(sent), 32'(65535 - 272));
        enable = 1'b0;
        wait_idle("wrap_idle0");
        chk("wrap_wc_max", 32'(word_count), 32'hFFFF);
        enable = 1'b1;
        @(negedge clk);
        stream(1, 1'b0, 100, sent);
        enable = 1'b0;
        wait_idle("wrap_idle1");
        chk("wrap_wc_zero", 32'(word_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
